// File: rtl/wb_regfile.sv
// Architectural register file with write-through bypass and a pending-write scoreboard.
// Reads and stall are combinational; write-back is always accepted, and only decode is held by stall.
module wb_regfile #(
  parameter int WIDTH   = 16,
  parameter int ADDR    = 3,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 Reg_write,
  input  logic [ADDR-1:0]      Rdest_num,
  input  logic [WIDTH-1:0]     data,
  input  logic [ADDR-1:0]      Rsrc1_num,
  input  logic [ADDR-1:0]      Rsrc2_num,
  input  logic                 src1_used,
  input  logic                 src2_used,
  input  logic                 issue_valid,
  input  logic                 issue_writes,
  input  logic [ADDR-1:0]      issue_dest,
  output logic [WIDTH-1:0]     Rsrc1_data,
  output logic [WIDTH-1:0]     Rsrc2_data,
  output logic                 stall,
  output logic [(1<<ADDR)-1:0] pending_out
);

  localparam int NREG = 1 << ADDR;

  logic [WIDTH-1:0] regs [NREG];
  logic [NREG-1:0]  pending;
  logic [NREG-1:0]  wb_hit;
  logic [NREG-1:0]  busy;
  logic [NREG-1:0]  set_vec;
  logic [NREG-1:0]  r0_mask;
  logic             wr_en;
  logic             issue_ok;

  // Register 0 is excluded from every scoreboard vector when it is hardwired to zero.
  assign r0_mask = R0_ZERO ? ~NREG'(1) : '1;

  assign wr_en  = Reg_write && !(R0_ZERO && (Rdest_num == '0));
  assign wb_hit = Reg_write ? (NREG'(1) << Rdest_num) : '0;
  assign busy   = pending & ~wb_hit & r0_mask;

  always_comb begin
    stall = 1'b0;
    if (issue_valid) begin
      stall = (src1_used    && busy[Rsrc1_num]) ||
              (src2_used    && busy[Rsrc2_num]) ||
              (issue_writes && busy[issue_dest]);
    end
  end

  assign issue_ok = issue_valid && !stall && issue_writes;
  assign set_vec  = issue_ok ? ((NREG'(1) << issue_dest) & r0_mask) : '0;

  always_comb begin
    Rsrc1_data = regs[Rsrc1_num];
    if (R0_ZERO && (Rsrc1_num == '0)) begin
      Rsrc1_data = '0;
    end else if (Reg_write && (Rdest_num == Rsrc1_num)) begin
      Rsrc1_data = data;
    end
  end

  always_comb begin
    Rsrc2_data = regs[Rsrc2_num];
    if (R0_ZERO && (Rsrc2_num == '0)) begin
      Rsrc2_data = '0;
    end else if (Reg_write && (Rdest_num == Rsrc2_num)) begin
      Rsrc2_data = data;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[Rdest_num] <= data;
    end
  end

  // Set is OR'ed after the clear so a new producer issued in its predecessor's write-back cycle stays pending.
  always_ff @(posedge clock) begin
    if (clear) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~wb_hit) | set_vec;
    end
  end

  assign pending_out = pending;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: vector table for hazards/bypass/reset, plus a fill-and-readback sequence.
module tb_wb_regfile;

  logic        clock = 1'b0;
  logic        clear, Reg_write, src1_used, src2_used, issue_valid, issue_writes;
  logic [2:0]  Rdest_num, Rsrc1_num, Rsrc2_num, issue_dest;
  logic [15:0] data, Rsrc1_data, Rsrc2_data;
  logic        stall;
  logic [7:0]  pending_out;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  wb_regfile #(.WIDTH(16), .ADDR(3), .R0_ZERO(1'b1)) dut (
    .clock(clock), .clear(clear), .Reg_write(Reg_write), .Rdest_num(Rdest_num), .data(data),
    .Rsrc1_num(Rsrc1_num), .Rsrc2_num(Rsrc2_num), .src1_used(src1_used), .src2_used(src2_used),
    .issue_valid(issue_valid), .issue_writes(issue_writes), .issue_dest(issue_dest),
    .Rsrc1_data(Rsrc1_data), .Rsrc2_data(Rsrc2_data), .stall(stall), .pending_out(pending_out)
  );

  typedef struct {
    logic        clr, rw;
    logic [2:0]  rd;
    logic [15:0] dat;
    logic [2:0]  s1, s2;
    logic        u1, u2, iv, iw;
    logic [2:0]  idst;
    logic        chk;
    logic [15:0] e1, e2;
    logic        es;
    logic [7:0]  ep;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] pend_q[$];
  logic [15:0] model [8];

  function automatic vec_t mk(input int clr, rw, rd, dat, s1, s2, u1, u2, iv, iw, idst,
                              input int chk, e1, e2, es, ep);
    vec_t v;
    v.clr = 1'(clr);  v.rw = 1'(rw);   v.rd = 3'(rd);   v.dat = 16'(dat);
    v.s1 = 3'(s1);    v.s2 = 3'(s2);   v.u1 = 1'(u1);   v.u2 = 1'(u2);
    v.iv = 1'(iv);    v.iw = 1'(iw);   v.idst = 3'(idst);
    v.chk = 1'(chk);  v.e1 = 16'(e1);  v.e2 = 16'(e2);  v.es = 1'(es); v.ep = 8'(ep);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    clear = v.clr; Reg_write = v.rw; Rdest_num = v.rd; data = v.dat;
    Rsrc1_num = v.s1; Rsrc2_num = v.s2; src1_used = v.u1; src2_used = v.u2;
    issue_valid = v.iv; issue_writes = v.iw; issue_dest = v.idst;
  endtask

  // Drive at negedge, check combinational outputs mid-cycle, check pending after the edge.
  task automatic apply(input vec_t v, input int idx);
    @(negedge clock);
    drive(v);
    #2;
    if (v.chk) begin
      chk($sformatf("v%0d_rd1", idx), 32'(Rsrc1_data), 32'(v.e1));
      chk($sformatf("v%0d_rd2", idx), 32'(Rsrc2_data), 32'(v.e2));
      chk($sformatf("v%0d_stall", idx), 32'(stall), 32'(v.es));
    end
    pend_q.push_back(v.ep);
    @(posedge clock);
    #1;
    if (pend_q.size() == 0) begin
      chk($sformatf("v%0d_sb_empty", idx), 32'd1, 32'd0);
    end else begin
      chk($sformatf("v%0d_pending", idx), 32'(pending_out), 32'(pend_q.pop_front()));
    end
  endtask

  initial begin
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    //         clr rw rd dat     s1 s2 u1 u2 iv iw idst chk e1      e2      es ep
    vecs.push_back(mk(1, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0, 0, 0,      0,      0, 'h00));
    vecs.push_back(mk(0, 0, 0, 0,      1, 2, 0, 0, 0, 0, 0, 1, 0,      0,      0, 'h00));
    vecs.push_back(mk(0, 0, 0, 0,      3, 4, 0, 0, 0, 0, 0, 1, 0,      0,      0, 'h00));
    vecs.push_back(mk(0, 0, 0, 0,      5, 6, 0, 0, 0, 0, 0, 1, 0,      0,      0, 'h00));
    vecs.push_back(mk(0, 0, 0, 0,      7, 0, 0, 0, 0, 0, 0, 1, 0,      0,      0, 'h00));
    vecs.push_back(mk(0, 1, 3, 'hBEEF, 3, 0, 0, 0, 0, 0, 0, 1, 'hBEEF, 0,      0, 'h00));
    vecs.push_back(mk(0, 0, 0, 0,      3, 3, 0, 0, 0, 0, 0, 1, 'hBEEF, 'hBEEF, 0, 'h00));
    vecs.push_back(mk(0, 1, 0, 'h1234, 0, 3, 0, 0, 0, 0, 0, 1, 0,      'hBEEF, 0, 'h00));
    vecs.push_back(mk(0, 0, 0, 0,      0, 3, 0, 0, 1, 1, 0, 1, 0,      'hBEEF, 0, 'h00));
    vecs.push_back(mk(0, 0, 0, 0,      0, 0, 0, 0, 1, 1, 5, 1, 0,      0,      0, 'h20));
    vecs.push_back(mk(0, 0, 0, 0,      5, 0, 1, 0, 1, 0, 0, 1, 0,      0,      1, 'h20));
    vecs.push_back(mk(0, 1, 5, 'h00AA, 5, 0, 1, 0, 1, 0, 0, 1, 'h00AA, 0,      0, 'h00));
    vecs.push_back(mk(0, 0, 0, 0,      5, 5, 0, 0, 0, 0, 0, 1, 'h00AA, 'h00AA, 0, 'h00));
    vecs.push_back(mk(0, 0, 0, 0,      0, 0, 0, 0, 1, 1, 1, 1, 0,      0,      0, 'h02));
    vecs.push_back(mk(0, 0, 0, 0,      0, 1, 0, 1, 1, 0, 0, 1, 0,      0,      1, 'h02));
    vecs.push_back(mk(0, 0, 0, 0,      0, 1, 0, 0, 1, 0, 0, 1, 0,      0,      0, 'h02));
    vecs.push_back(mk(0, 0, 0, 0,      1, 0, 1, 0, 0, 0, 0, 1, 0,      0,      0, 'h02));
    vecs.push_back(mk(0, 0, 0, 0,      0, 0, 0, 0, 1, 1, 2, 1, 0,      0,      0, 'h06));
    vecs.push_back(mk(0, 0, 0, 0,      0, 0, 0, 0, 1, 1, 2, 1, 0,      0,      1, 'h06));
    vecs.push_back(mk(0, 1, 2, 'h5555, 2, 0, 0, 0, 1, 1, 2, 1, 'h5555, 0,      0, 'h06));
    vecs.push_back(mk(0, 1, 1, 'h1111, 1, 2, 0, 0, 0, 0, 0, 1, 'h1111, 'h5555, 0, 'h04));
    vecs.push_back(mk(0, 1, 2, 'h2222, 1, 2, 0, 0, 0, 0, 0, 1, 'h1111, 'h2222, 0, 'h00));
    vecs.push_back(mk(0, 0, 0, 0,      0, 0, 0, 0, 1, 1, 4, 1, 0,      0,      0, 'h10));
    vecs.push_back(mk(0, 0, 0, 0,      0, 0, 0, 0, 1, 1, 6, 1, 0,      0,      0, 'h50));
    vecs.push_back(mk(1, 1, 4, 'hFFFF, 0, 0, 0, 0, 1, 1, 3, 0, 0,      0,      0, 'h00));
    vecs.push_back(mk(0, 0, 0, 0,      4, 3, 0, 0, 0, 0, 0, 1, 0,      0,      0, 'h00));
    vecs.push_back(mk(0, 0, 0, 0,      6, 4, 1, 1, 1, 1, 6, 1, 0,      0,      0, 'h40));

    foreach (vecs[i]) apply(vecs[i], i);

    // Fill r1..r7 with distinct values, then read each back from the array on both ports.
    for (int r = 1; r < 8; r++) begin
      model[r] = 16'($urandom_range(1, 16'hFFFF));
      @(negedge clock);
      drive(mk(0, 1, r, int'(model[r]), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clock);
    end
    @(negedge clock);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    chk("fill_pending", 32'(pending_out), 32'h00);
    for (int r = 1; r < 8; r++) begin
      Rsrc1_num = 3'(r);
      Rsrc2_num = 3'(8 - r);
      #1;
      chk($sformatf("fill_rd1_r%0d", r), 32'(Rsrc1_data), 32'(model[r]));
      chk($sformatf("fill_rd2_r%0d", 8 - r), 32'(Rsrc2_data), 32'(model[8 - r]));
    end
    chk("sb_drained", 32'(pend_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
